keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 178 +++++++++++++++++
 tb/tb_keypad_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 3x4 matrix keypad scanner: column scan, row debounce, one valid pulse per press,
// hold flag while pressed, plus an active-low one-hot digit strobe.
module keypad_scan #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int SCAN_DWELL   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_hold,
    output logic [9:0] keypad,
    output logic [1:0] dbg_state
);

    localparam int DW = $clog2(SCAN_DWELL + 1);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    rs_q, rs_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    key_data_q, key_data_d;
    logic          key_valid_q, key_valid_d;
    logic          key_hold_q, key_hold_d;
    logic [9:0]    keypad_q, keypad_d;

    logic          last_dwell;
    logic          one_low;
    logic          rs_match;
    logic          rs_idle;
    logic [CW-1:0] cnt_inc;
    logic          cnt_done;
    logic [1:0]    col_next;
    logic [3:0]    key_code;

    assign last_dwell = (dwell_q == DW'(SCAN_DWELL - 1));
    assign one_low    = ($countones(~rs_q) == 1);
    assign rs_match   = (rs_q == row_q);
    assign rs_idle    = (rs_q == 4'hF);
    // Saturating increment: the counter parks at DEBOUNCE_CYC instead of wrapping.
    assign cnt_inc    = (cnt_q == CW'(DEBOUNCE_CYC)) ? cnt_q : cnt_q + CW'(1);
    assign cnt_done   = (cnt_inc == CW'(DEBOUNCE_CYC));
    assign col_next   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

    always_comb begin
        key_code = 4'd0;
        unique case (row_q)
            4'b1110: key_code = 4'd1 + {2'b00, col_q};
            4'b1101: key_code = 4'd4 + {2'b00, col_q};
            4'b1011: key_code = 4'd7 + {2'b00, col_q};
            default: begin
                unique case (col_q)
                    2'd0:    key_code = 4'd10;
                    2'd1:    key_code = 4'd0;
                    default: key_code = 4'd11;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SCAN;
            col_q       <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            row_q       <= 4'hF;
            key_data_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_hold_q  <= 1'b0;
            keypad_q    <= 10'h3FF;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            rs_q        <= rs_d;
            row_q       <= row_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            key_hold_q  <= key_hold_d;
            keypad_q    <= keypad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SCAN:     if (last_dwell && one_low) state_d = S_DEBOUNCE;
            S_DEBOUNCE: if (!rs_match) state_d = S_SCAN;
                        else if (cnt_done) state_d = S_HELD;
            S_HELD:     if (rs_idle) state_d = S_RELEASE;
            S_RELEASE:  if (!rs_idle) state_d = S_HELD;
                        else if (cnt_done) state_d = S_SCAN;
            default:    state_d = S_SCAN;
        endcase
    end

    always_comb begin
        sync1_d     = key_row;
        rs_d        = sync1_q;
        col_d       = col_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        key_hold_d  = key_hold_q;
        keypad_d    = 10'h3FF;
        unique case (state_q)
            S_SCAN: begin
                if (!last_dwell) begin
                    dwell_d = dwell_q + DW'(1);
                end else if (one_low) begin
                    row_d   = rs_q;
                    cnt_d   = '0;
                    dwell_d = '0;
                end else begin
                    col_d   = col_next;
                    dwell_d = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!rs_match) begin
                    col_d   = col_next;
                    dwell_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_done) begin
                        key_valid_d = 1'b1;
                        key_data_d  = key_code;
                        key_hold_d  = 1'b1;
                        // '*' and '#' have no digit strobe.
                        if (key_code < 4'd10) keypad_d = ~(10'd1 << key_code);
                    end
                end
            end
            S_HELD: begin
                if (rs_idle) cnt_d = '0;
            end
            S_RELEASE: begin
                if (rs_idle) begin
                    cnt_d = cnt_inc;
                    if (cnt_done) begin
                        key_hold_d = 1'b0;
                        col_d      = 2'd0;
                        dwell_d    = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign key_col   = ~(3'b001 << col_q);
    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_hold  = key_hold_q;
    assign keypad    = keypad_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural keypad matrix pulls one or more rows
// low whenever the pressed key's column is driven.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_hold;
    logic [9:0] keypad;
    logic [1:0] dbg_state;

    logic       press_en;
    logic [1:0] press_col;
    logic [3:0] press_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign key_row = (press_en && key_col[press_col] == 1'b0) ? press_mask : 4'hF;

    keypad_scan #(.DEBOUNCE_CYC(20), .SCAN_DWELL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_hold  (key_hold),
        .keypad    (keypad),
        .dbg_state (dbg_state)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        press_en = 1'b0;
        repeat (3) step();
        checks++; if (key_col !== 3'b110) begin failures++; $display("FAIL reset_col got=%b exp=110", key_col); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", key_hold); end
        checks++; if (key_data !== 4'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", key_data); end
        checks++; if (keypad !== 10'h3FF) begin failures++; $display("FAIL reset_keypad got=%h exp=3ff", keypad); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [2:0] exp_col;
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_col = ~(3'b001 << ((k / 4) % 3));
            checks++; if (key_col !== exp_col) begin failures++; $display("FAIL idle_col cyc=%0d got=%b exp=%b", k, key_col, exp_col); end
            checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", k, key_valid); end
            checks++; if (keypad !== 10'h3FF) begin failures++; $display("FAIL idle_keypad cyc=%0d got=%h exp=3ff", k, keypad); end
        end
    endtask

    task automatic test_press_5();
        int nvalid = 0;
        int lat = -1;
        int bad_strobe = 0;
        press_col = 2'd1; press_mask = 4'b1101; press_en = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (key_valid === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat = i;
                    checks++; if (key_data !== 4'd5) begin failures++; $display("FAIL press5_data got=%0d exp=5", key_data); end
                    checks++; if (keypad !== 10'h3DF) begin failures++; $display("FAIL press5_keypad got=%h exp=3df", keypad); end
                    checks++; if (key_hold !== 1'b1) begin failures++; $display("FAIL press5_hold_at_valid got=%b exp=1", key_hold); end
                end
            end else if (keypad !== 10'h3FF) begin
                bad_strobe++;
            end
        end
        checks++; if (nvalid !== 1) begin failures++; $display("FAIL press5_pulses got=%0d exp=1", nvalid); end
        checks++; if (lat < 1 || lat > 35) begin failures++; $display("FAIL press5_latency got=%0d exp=1..35", lat); end
        checks++; if (bad_strobe !== 0) begin failures++; $display("FAIL press5_idle_strobe got=%0d exp=0", bad_strobe); end
        checks++; if (key_hold !== 1'b1) begin failures++; $display("FAIL press5_hold got=%b exp=1", key_hold); end
        press_en = 1'b0;
        nvalid = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (key_valid === 1'b1) nvalid++;
            if (i == 20) begin
                checks++; if (key_hold !== 1'b1) begin failures++; $display("FAIL release5_hold_early got=%b exp=1", key_hold); end
            end
            if (i == 25) begin
                checks++; if (key_hold !== 1'b0) begin failures++; $display("FAIL release5_hold_late got=%b exp=0", key_hold); end
            end
        end
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL release5_pulses got=%0d exp=0", nvalid); end
        checks++; if (key_data !== 4'd5) begin failures++; $display("FAIL release5_data_kept got=%0d exp=5", key_data); end
    endtask

    task automatic test_bounce_7();
        int nbounce = 0;
        int nvalid = 0;
        press_col = 2'd0; press_mask = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            press_en = (i % 2 == 0);
            step();
            if (key_valid === 1'b1) nbounce++;
        end
        press_en = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            step();
            if (key_valid === 1'b1) begin
                nvalid++;
                checks++; if (key_data !== 4'd7) begin failures++; $display("FAIL bounce7_data got=%0d exp=7", key_data); end
                checks++; if (keypad !== 10'h37F) begin failures++; $display("FAIL bounce7_keypad got=%h exp=37f", keypad); end
            end
        end
        checks++; if (nbounce !== 0) begin failures++; $display("FAIL bounce7_early_pulse got=%0d exp=0", nbounce); end
        checks++; if (nvalid !== 1) begin failures++; $display("FAIL bounce7_pulses got=%0d exp=1", nvalid); end
        press_en = 1'b0;
        repeat (40) step();
        checks++; if (key_hold !== 1'b0) begin failures++; $display("FAIL bounce7_released got=%b exp=0", key_hold); end
    endtask

    task automatic test_hash();
        int nvalid = 0;
        int bad_strobe = 0;
        press_col = 2'd2; press_mask = 4'b0111; press_en = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            step();
            if (keypad !== 10'h3FF) bad_strobe++;
            if (key_valid === 1'b1) begin
                nvalid++;
                checks++; if (key_data !== 4'd11) begin failures++; $display("FAIL hash_data got=%0d exp=11", key_data); end
            end
        end
        checks++; if (nvalid !== 1) begin failures++; $display("FAIL hash_pulses got=%0d exp=1", nvalid); end
        checks++; if (bad_strobe !== 0) begin failures++; $display("FAIL hash_keypad got=%0d exp=0", bad_strobe); end
        press_en = 1'b0;
        repeat (40) step();
    endtask

    task automatic test_two_rows();
        int nvalid = 0;
        int saw_col2 = 0;
        press_col = 2'd0; press_mask = 4'b1100; press_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (key_valid === 1'b1) nvalid++;
            if (key_col === 3'b011) saw_col2++;
        end
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL tworow_pulses got=%0d exp=0", nvalid); end
        checks++; if (saw_col2 == 0) begin failures++; $display("FAIL tworow_scan got=%0d exp=>0", saw_col2); end
        checks++; if (key_hold !== 1'b0) begin failures++; $display("FAIL tworow_hold got=%b exp=0", key_hold); end
        checks++; if (key_data !== 4'd11) begin failures++; $display("FAIL tworow_data_kept got=%0d exp=11", key_data); end
        press_en = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset_mid_debounce();
        int nvalid = 0;
        rst = 1'b1;
        press_col = 2'd0; press_mask = 4'b1110; press_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        // Sync fills after 2 edges, capture on edge 4, debounce count hits 15 on edge 19.
        for (int i = 1; i <= 19; i++) begin
            step();
            if (key_valid === 1'b1) nvalid++;
        end
        rst = 1'b1;
        step();
        press_en = 1'b0;
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL rstdb_pulses got=%0d exp=0", nvalid); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rstdb_valid got=%b exp=0", key_valid); end
        checks++; if (key_hold !== 1'b0) begin failures++; $display("FAIL rstdb_hold got=%b exp=0", key_hold); end
        checks++; if (key_data !== 4'd0) begin failures++; $display("FAIL rstdb_data got=%0d exp=0", key_data); end
        checks++; if (keypad !== 10'h3FF) begin failures++; $display("FAIL rstdb_keypad got=%h exp=3ff", keypad); end
        checks++; if (key_col !== 3'b110) begin failures++; $display("FAIL rstdb_col got=%b exp=110", key_col); end
        rst = 1'b0;
        step();
        checks++; if (key_col !== 3'b110) begin failures++; $display("FAIL rstdb_col_after got=%b exp=110", key_col); end
        for (int i = 1; i <= 60; i++) begin
            step();
            if (key_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL rstdb_late_pulse got=%0d exp=0", nvalid); end
    endtask

    initial begin
        rst = 1'b1;
        press_en = 1'b0;
        press_col = 2'd0;
        press_mask = 4'hF;
        test_reset();
        test_idle_scan();
        test_press_5();
        test_bounce_7();
        test_hash();
        test_two_rows();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
